// File: rtl/commit_trace_buffer.sv
// Retire-event recorder: classifies each committed instruction, stamps it with an
// instruction number and queues it in a FIFO drained by a valid/ready port.
module commit_trace_buffer #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       trace_en,
   input  logic                       skip_nop,
   input  logic                       cm_valid,
   input  logic [DATA_W-1:0]          cm_pc,
   input  logic                       cm_reg_wr,
   input  logic                       cm_mem_rd,
   input  logic                       cm_mem_wr,
   input  logic                       cm_halt,
   input  logic [REG_W-1:0]           cm_wreg,
   input  logic [DATA_W-1:0]          cm_wdata,
   input  logic [DATA_W-1:0]          cm_addr,
   input  logic [DATA_W-1:0]          cm_mdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [2:0]                 out_kind,
   output logic [CNT_W-1:0]           out_inum,
   output logic [DATA_W-1:0]          out_pc,
   output logic [DATA_W-1:0]          out_wdata,
   output logic [DATA_W-1:0]          out_addr,
   output logic [DATA_W-1:0]          out_mdata,
   output logic [REG_W-1:0]           out_wreg,
   output logic [$clog2(DEPTH):0]     count,
   output logic [CNT_W-1:0]           inst_count,
   output logic [CNT_W-1:0]           cycle_count,
   output logic [CNT_W-1:0]           drop_count,
   output logic                       halted,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] K_NOP  = 3'd0;
   localparam logic [2:0] K_REG  = 3'd1;
   localparam logic [2:0] K_LD   = 3'd2;
   localparam logic [2:0] K_ST   = 3'd3;
   localparam logic [2:0] K_STU  = 3'd4;
   localparam logic [2:0] K_HALT = 3'd5;

   typedef struct packed {
      logic [2:0]        kind;
      logic [CNT_W-1:0]  inum;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] mdata;
      logic [REG_W-1:0]  wreg;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          head_reg;
   entry_t          new_entry;
   logic [AW:0]     wr_reg;
   logic [AW:0]     rd_reg;
   logic [AW-1:0]   rd_nxt_idx;
   logic [2:0]      kind;
   logic            accept;
   logic            push_req;
   logic            full;
   logic            pop;
   logic            push;
   logic            drop;

   assign count      = wr_reg - rd_reg;
   assign out_valid  = (count != '0);
   assign full       = (count == (AW+1)'(DEPTH));
   assign pop        = out_valid & out_ready;
   assign rd_nxt_idx = rd_reg[AW-1:0] + AW'(1);

   always_comb begin
      kind = K_NOP;
      if (cm_halt)                    kind = K_HALT;
      else if (cm_reg_wr & cm_mem_wr) kind = K_STU;
      else if (cm_reg_wr & cm_mem_rd) kind = K_LD;
      else if (cm_reg_wr)             kind = K_REG;
      else if (cm_mem_wr)             kind = K_ST;
   end

   always_comb begin
      accept   = cm_valid & ~halted;
      push_req = accept & ((kind == K_HALT) |
                           (trace_en & ~(skip_nop & (kind == K_NOP))));
      // A full FIFO still accepts a push when the head leaves on the same edge.
      push     = push_req & (~full | pop);
      drop     = push_req & full & ~pop;
      new_entry = '{kind: kind, inum: inst_count, pc: cm_pc, wdata: cm_wdata,
                    addr: cm_addr, mdata: cm_mdata, wreg: cm_wreg};
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_reg[AW-1:0]] <= new_entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_reg      <= '0;
         rd_reg      <= '0;
         head_reg    <= '0;
         inst_count  <= '0;
         cycle_count <= '0;
         drop_count  <= '0;
         halted      <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (push) wr_reg <= wr_reg + (AW+1)'(1);
         if (pop)  rd_reg <= rd_reg + (AW+1)'(1);
         // Head register: a fresh entry bypasses the RAM when it becomes head.
         if (push && (count == '0 || (count == (AW+1)'(1) && pop)))
            head_reg <= new_entry;
         else if (pop && count > (AW+1)'(1))
            head_reg <= mem[rd_nxt_idx];
         if (accept) inst_count <= inst_count + CNT_W'(1);
         if (!halted) cycle_count <= cycle_count + CNT_W'(1);
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
         end
         if (accept && kind == K_HALT) halted <= 1'b1;
      end
   end

   assign out_kind  = head_reg.kind;
   assign out_inum  = head_reg.inum;
   assign out_pc    = head_reg.pc;
   assign out_wdata = head_reg.wdata;
   assign out_addr  = head_reg.addr;
   assign out_mdata = head_reg.mdata;
   assign out_wreg  = head_reg.wreg;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed self-checking bench for commit_trace_buffer: a vector table for the
// basic commit stream plus hand sequences for overflow, halt and reset corners.
module tb_commit_trace_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        trace_en = 1'b1, skip_nop = 1'b0;
   logic        cm_valid = 1'b0;
   logic [15:0] cm_pc = '0, cm_wdata = '0, cm_addr = '0, cm_mdata = '0;
   logic        cm_reg_wr = 1'b0, cm_mem_rd = 1'b0, cm_mem_wr = 1'b0, cm_halt = 1'b0;
   logic [2:0]  cm_wreg = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [2:0]  out_kind;
   logic [31:0] out_inum;
   logic [15:0] out_pc, out_wdata, out_addr, out_mdata;
   logic [2:0]  out_wreg;
   logic [4:0]  count;
   logic [31:0] inst_count, cycle_count, drop_count;
   logic        halted, overflow;

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;   // expected cycle_count since reset release
   bit tb_halted = 0;

   commit_trace_buffer dut (
      .clk(clk), .rst(rst), .trace_en(trace_en), .skip_nop(skip_nop),
      .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_reg_wr(cm_reg_wr), .cm_mem_rd(cm_mem_rd),
      .cm_mem_wr(cm_mem_wr), .cm_halt(cm_halt), .cm_wreg(cm_wreg), .cm_wdata(cm_wdata),
      .cm_addr(cm_addr), .cm_mdata(cm_mdata), .out_valid(out_valid), .out_ready(out_ready),
      .out_kind(out_kind), .out_inum(out_inum), .out_pc(out_pc), .out_wdata(out_wdata),
      .out_addr(out_addr), .out_mdata(out_mdata), .out_wreg(out_wreg), .count(count),
      .inst_count(inst_count), .cycle_count(cycle_count), .drop_count(drop_count),
      .halted(halted), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid, rw, mr, mw, h, ready;
      logic [2:0]  wreg;
      logic [15:0] wdata, addr, mdata, pc;
      logic        e_valid;
      logic [2:0]  e_kind;
      logic [31:0] e_inum;
      logic [15:0] e_pc, e_wdata, e_addr, e_mdata;
      logic [2:0]  e_wreg;
      logic [4:0]  e_count;
      logic [31:0] e_icnt;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else
         $display("ok   %s = 0x%0h", name, act);
   endtask

   task automatic step();
      @(posedge clk);
      if (!tb_halted) ncyc++;
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                        input logic h, input logic [2:0] wreg, input logic [15:0] wdata,
                        input logic [15:0] addr, input logic [15:0] mdata, input logic [15:0] pc);
      cm_valid = v; cm_reg_wr = rw; cm_mem_rd = mr; cm_mem_wr = mw; cm_halt = h;
      cm_wreg = wreg; cm_wdata = wdata; cm_addr = addr; cm_mdata = mdata; cm_pc = pc;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ncyc = 0;
      tb_halted = 0;
   endtask

   initial begin
      vecs[0] = '{1,1,0,0,0,1, 3'd3,16'h0012,16'h0000,16'h0000,16'h0000,
                  1,3'd1,32'd0,16'h0000,16'h0012,16'h0000,16'h0000,3'd3,5'd1,32'd1};
      vecs[1] = '{1,1,1,0,0,1, 3'd1,16'h1234,16'h0040,16'h0000,16'h0002,
                  1,3'd2,32'd1,16'h0002,16'h1234,16'h0040,16'h0000,3'd1,5'd1,32'd2};
      vecs[2] = '{1,0,0,1,0,1, 3'd0,16'h0000,16'h0042,16'hBEEF,16'h0004,
                  1,3'd3,32'd2,16'h0004,16'h0000,16'h0042,16'hBEEF,3'd0,5'd1,32'd3};
      vecs[3] = '{0,0,0,0,0,1, 3'd0,16'h0000,16'h0000,16'h0000,16'h0000,
                  0,3'd3,32'd2,16'h0004,16'h0000,16'h0042,16'hBEEF,3'd0,5'd0,32'd3};
      vecs[4] = '{1,1,0,1,0,0, 3'd5,16'h0055,16'h0060,16'h0077,16'h0006,
                  1,3'd4,32'd3,16'h0006,16'h0055,16'h0060,16'h0077,3'd5,5'd1,32'd4};
      vecs[5] = '{0,0,0,0,0,1, 3'd0,16'h0000,16'h0000,16'h0000,16'h0000,
                  0,3'd4,32'd3,16'h0006,16'h0055,16'h0060,16'h0077,3'd5,5'd0,32'd4};

      // Reset state
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_out_pc", out_pc, 0);
      do_reset();
      chk("post_rst_cycle_count", cycle_count, 0);

      // Basic commit stream
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].valid, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].h, vecs[i].wreg,
               vecs[i].wdata, vecs[i].addr, vecs[i].mdata, vecs[i].pc);
         out_ready = vecs[i].ready;
         step();
         chk($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
         chk($sformatf("v%0d_kind", i),  out_kind,  vecs[i].e_kind);
         chk($sformatf("v%0d_inum", i),  out_inum,  vecs[i].e_inum);
         chk($sformatf("v%0d_pc", i),    out_pc,    vecs[i].e_pc);
         chk($sformatf("v%0d_wdata", i), out_wdata, vecs[i].e_wdata);
         chk($sformatf("v%0d_addr", i),  out_addr,  vecs[i].e_addr);
         chk($sformatf("v%0d_mdata", i), out_mdata, vecs[i].e_mdata);
         chk($sformatf("v%0d_wreg", i),  out_wreg,  vecs[i].e_wreg);
         chk($sformatf("v%0d_count", i), count,     vecs[i].e_count);
         chk($sformatf("v%0d_icnt", i),  inst_count, vecs[i].e_icnt);
      end

      // Bubbles
      idle();
      for (int i = 0; i < 5; i++) step();
      chk("bubble_inst_count", inst_count, 4);
      chk("bubble_count", count, 0);
      chk("bubble_cycle_count", cycle_count, ncyc);

      // Overflow: 20 commits into a 16-deep FIFO with no consumer
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 16'(i), 16'h0, 16'h0, 16'(2*i));
         step();
      end
      idle();
      chk("ovf_count", count, 16);
      chk("ovf_drop_count", drop_count, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_inst_count", inst_count, 20);
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain%0d_valid", i), out_valid, 1);
         chk($sformatf("drain%0d_inum", i), out_inum, i);
         chk($sformatf("drain%0d_wdata", i), out_wdata, i);
         step();
      end
      chk("drain_empty_valid", out_valid, 0);
      chk("drain_empty_count", count, 0);
      chk("drain_cycle_count", cycle_count, ncyc);

      // Asynchronous reset with 5 entries held
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 16'h00A0, 16'h0, 16'h0, 16'h0);
         step();
      end
      idle();
      chk("pre_rst_count", count, 5);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_count", count, 0);
      chk("arst_inst_count", inst_count, 0);
      chk("arst_cycle_count", cycle_count, 0);
      chk("arst_drop_count", drop_count, 0);
      chk("arst_overflow", overflow, 0);
      chk("arst_out_wdata", out_wdata, 0);
      do_reset();

      // Full FIFO with simultaneous push and pop
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 16'(i), 16'h0, 16'h0, 16'h0);
         step();
      end
      chk("full_count", count, 16);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 16'h0100, 16'h0, 16'h0, 16'h0);
      out_ready = 1'b1;
      step();
      idle();
      out_ready = 1'b0;
      chk("pushpop_count", count, 16);
      chk("pushpop_drop", drop_count, 0);
      chk("pushpop_overflow", overflow, 0);
      chk("pushpop_head_inum", out_inum, 1);

      // skip_nop with halt freeze
      do_reset();
      skip_nop = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0011, 16'h0, 16'h0, 16'h0010); step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0, 16'h0, 16'h0012); step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, 16'h0, 16'h0, 16'h0014); step();
      tb_halted = 1;
      chk("halt_flag", halted, 1);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'h0099, 16'h0, 16'h0, 16'h0016); step();
      idle();
      for (int i = 0; i < 3; i++) step();
      chk("halt_inst_count", inst_count, 3);
      chk("halt_cycle_count", cycle_count, ncyc);
      chk("halt_count", count, 2);
      chk("halt_head_kind", out_kind, 1);
      chk("halt_head_inum", out_inum, 0);
      out_ready = 1'b1;
      step();
      chk("halt_e2_kind", out_kind, 5);
      chk("halt_e2_inum", out_inum, 2);
      chk("halt_e2_pc", out_pc, 16'h0014);
      step();
      chk("halt_drained_valid", out_valid, 0);
      chk("halt_cycle_frozen", cycle_count, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
